// File: rtl/mssd_pkg.sv
// Shared types and constants for the MSSD serial frame transmitter.
// The header packing lives here so that every user builds the header the same way.
package mssd_pkg;

  localparam int HDR_BITS = 8;
  localparam int DEST_W   = 2;
  localparam int LEN_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    HDR,
    DATA,
    STOP,
    GAP
  } tx_state_t;

  // Header on the wire is {len, dest}, sent LSB first, so dest[0] leads.
  function automatic logic [HDR_BITS-1:0] pack_hdr(input logic [LEN_W-1:0]  len,
                                                   input logic [DEST_W-1:0] dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/piso8.sv
// 8-bit parallel-in serial-out shift register; shifts right, serial bit is the LSB.
// Load takes priority over shift.
module piso8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       en,
  input  logic [7:0] d,
  output logic       so
);

  logic [7:0] q;

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
    else if (en) q <= {1'b0, q[7:1]};
  end

  assign so = q[0];

endmodule

// File: rtl/mssd_frame_tx.sv
// MSSD frame transmitter: start bit, {len,dest} header, 8*len payload bits, stop bit,
// then at least GAP idle-high bits. One bit per clock; the line is a registered output.
module mssd_frame_tx #(
  parameter int GAP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [mssd_pkg::DEST_W-1:0] req_dest,
  input  logic [mssd_pkg::LEN_W-1:0]  req_len,
  output logic                        req_ready,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        sOut,
  output logic                        busy,
  output logic                        done,
  output logic                        underrun
);

  import mssd_pkg::*;

  localparam int                GAP_W  = $clog2(GAP + 1);
  // The idle cycle that accepts the next request is itself one of the GAP idle bits.
  localparam logic [GAP_W-1:0]  GAP_LD = GAP_W'(GAP - 1);

  tx_state_t                state_q, state_d;
  logic [DEST_W-1:0]        dest_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic [LEN_W-1:0]         fetched_q, fetched_d;
  logic [LEN_W:0]           fetch_sum;
  logic [2:0]               bit_q, bit_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [7:0]               hold_q;
  logic                     hold_full_q;
  logic                     sout_d;
  logic                     req_fire, byte_fire, byte_last, reload, shift_en, piso_so;
  logic [7:0]               load_byte;
  logic [HDR_BITS-1:0]      hdr;

  assign hdr        = pack_hdr(len_q, dest_q);
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == STOP);
  assign req_fire   = req_valid && req_ready;
  assign byte_ready = (state_q inside {START, HDR, DATA}) && !hold_full_q && (fetched_q < len_q);
  assign byte_fire  = byte_valid && byte_ready;
  assign byte_last  = (bit_q == 3'd7);

  // A reload feeds the next byte to the line on the edge after the last header or data bit.
  assign reload    = byte_last && (((state_q == HDR) && (len_q != '0)) ||
                                   ((state_q == DATA) && (rem_q != '0)));
  assign underrun  = reload && !hold_full_q;
  assign load_byte = hold_full_q ? hold_q : 8'h00;
  assign shift_en  = (state_q == DATA) && !reload;

  // Bit 0 of a reloaded byte goes straight to the line register; the shifter keeps the rest.
  piso8 u_piso (
    .clk (clk),
    .rst (rst),
    .ld  (reload),
    .en  (shift_en),
    .d   ({1'b0, load_byte[7:1]}),
    .so  (piso_so)
  );

  // An underrun byte counts as fetched; the clamp keeps a same-cycle late byte from wrapping.
  always_comb begin
    fetch_sum = {1'b0, fetched_q} + (LEN_W+1)'(byte_fire) + (LEN_W+1)'(underrun);
    fetched_d = (fetch_sum > {1'b0, len_q}) ? len_q : fetch_sum[LEN_W-1:0];
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d = state_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    sout_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = START;
          bit_d   = 3'd0;
          sout_d  = 1'b0;
        end
      end
      START: begin
        state_d = HDR;
        sout_d  = hdr[0];
      end
      HDR: begin
        bit_d = bit_q + 3'd1;
        if (!byte_last) begin
          sout_d = hdr[bit_d];
        end else if (len_q != '0) begin
          state_d = DATA;
          rem_d   = len_q - LEN_W'(1);
          sout_d  = load_byte[0];
        end else begin
          state_d = STOP;
        end
      end
      DATA: begin
        bit_d = bit_q + 3'd1;
        if (!byte_last) begin
          sout_d = piso_so;
        end else if (rem_q != '0) begin
          rem_d  = rem_q - LEN_W'(1);
          sout_d = load_byte[0];
        end else begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (GAP > 1) begin
          state_d = mssd_pkg::GAP;
          gap_d   = GAP_LD;
        end else begin
          state_d = IDLE;
        end
      end
      mssd_pkg::GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
        else                    gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sOut        <= 1'b1;
      dest_q      <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      fetched_q   <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sOut    <= sout_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      if (req_fire) begin
        dest_q    <= req_dest;
        len_q     <= req_len;
        fetched_q <= '0;
      end else begin
        fetched_q <= fetched_d;
      end
      // A byte arriving on a reload cycle lands in the holding register, never in the shifter.
      if (byte_fire) begin
        hold_q      <= byte_data;
        hold_full_q <= 1'b1;
      end else if (reload || (state_q == STOP)) begin
        hold_full_q <= 1'b0;
      end
    end
  end

endmodule
